// File: rtl/usb_defs.sv
// usb_defs -- shared USB transmit definitions.
// Holds the PID nibble constants, the handshake and data type encodings,
// the CRC16 polynomial and initial value, the transmit FSM state type and
// small helpers that map type encodings to PID bytes and advance the CRC.
// Optional feature macro: USB_TX_UNDERRUN_EN adds the ABORT state.
package usb_defs;

  // Handshake type encodings on tx_trn_hsk_type
  localparam logic [1:0] HSK_ACK   = 2'b00;
  localparam logic [1:0] HSK_NYET  = 2'b01;
  localparam logic [1:0] HSK_NAK   = 2'b10;
  localparam logic [1:0] HSK_STALL = 2'b11;

  // Data type encodings on tx_trn_data_type
  localparam logic [1:0] DT_DATA0 = 2'b00;
  localparam logic [1:0] DT_DATA2 = 2'b01;
  localparam logic [1:0] DT_DATA1 = 2'b10;
  localparam logic [1:0] DT_MDATA = 2'b11;

  // PID nibbles (the wire byte is {~nibble, nibble})
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;

  // CRC16: polynomial 0x8005 processed LSB first, hence the reflected form
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HSK    = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5
`ifdef USB_TX_UNDERRUN_EN
    ,
    ST_ABORT  = 3'd6
`endif
  } tx_state_e;

  function automatic logic [3:0] hsk_pid(input logic [1:0] t);
    logic [3:0] p;
    case (t)
      HSK_ACK:  p = PID_ACK;
      HSK_NYET: p = PID_NYET;
      HSK_NAK:  p = PID_NAK;
      default:  p = PID_STALL;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] data_pid(input logic [1:0] t);
    logic [3:0] p;
    case (t)
      DT_DATA0: p = PID_DATA0;
      DT_DATA2: p = PID_DATA2;
      DT_DATA1: p = PID_DATA1;
      default:  p = PID_MDATA;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] nib);
    return {~nib, nib};
  endfunction

  // One byte of CRC16, bit 0 of the data first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16 -- running CRC16 over accepted payload bytes.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, loads CRC16_INIT
//   clear_i  : reload CRC16_INIT (takes priority over strobe_i)
//   data_i   : payload byte
//   strobe_i : fold data_i into the CRC this cycle
//   crc_o    : current CRC register (not inverted)
module usb_crc16
  import usb_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  input  logic        strobe_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (strobe_i) begin
      crc_d = crc16_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_trn_tx.sv
// usb_trn_tx -- USB transaction-level packet transmitter.
// Turns handshake requests and payload streams into a PID/data/CRC byte
// stream towards the PHY.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   tx_trn_send_hsk      : handshake request, held until tx_trn_hsk_sent
//   tx_trn_hsk_type      : 00 ACK, 10 NAK, 11 STALL, 01 NYET
//   tx_trn_hsk_sent      : handshake byte accepted (same cycle as m_tready)
//   tx_trn_data_start    : data packet in progress
//   tx_trn_data_type     : 00 DATA0, 10 DATA1, 01 DATA2, 11 MDATA
//   tx_trn_data*         : payload byte, valid, last, ready
//   m_tdata..m_tuser     : byte stream to PHY; m_tuser flags an aborted packet
//   tx_busy_o            : high whenever the FSM is not idle
// Handshake rule on m_*: a byte transfers in a cycle with m_tvalid && m_tready;
// while m_tvalid && !m_tready the byte on m_tdata is held unchanged. The payload
// side uses the same rule with tx_trn_data_valid/tx_trn_data_ready.
// Optional feature macro: USB_TX_UNDERRUN_EN. When defined a payload gap in
// DATA aborts the packet (ABORT state, m_tuser=1); otherwise gaps stall output.
module usb_trn_tx
  import usb_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_trn_send_hsk,
  input  logic [1:0] tx_trn_hsk_type,
  output logic       tx_trn_hsk_sent,
  input  logic       tx_trn_data_start,
  input  logic [1:0] tx_trn_data_type,
  input  logic [7:0] tx_trn_data,
  input  logic       tx_trn_data_valid,
  input  logic       tx_trn_data_last,
  output logic       tx_trn_data_ready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       tx_busy_o
);

  tx_state_e   state_q, state_d;
  logic [1:0]  hsk_type_q, hsk_type_d;
  logic [1:0]  data_type_q, data_type_d;
  logic        crc_clear, crc_strobe;
  logic [15:0] crc;
`ifdef USB_TX_UNDERRUN_EN
  logic        abort_sent_q, abort_sent_d;
`endif

  usb_crc16 u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (crc_clear),
    .data_i   (tx_trn_data),
    .strobe_i (crc_strobe),
    .crc_o    (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hsk_type_q  <= 2'b00;
      data_type_q <= 2'b00;
`ifdef USB_TX_UNDERRUN_EN
      abort_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hsk_type_q  <= hsk_type_d;
      data_type_q <= data_type_d;
`ifdef USB_TX_UNDERRUN_EN
      abort_sent_q <= abort_sent_d;
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    hsk_type_d        = hsk_type_q;
    data_type_d       = data_type_q;
    m_tdata           = 8'h00;
    m_tvalid          = 1'b0;
    m_tlast           = 1'b0;
    m_tuser           = 1'b0;
    tx_trn_data_ready = 1'b0;
    tx_trn_hsk_sent   = 1'b0;
    crc_clear         = 1'b0;
    crc_strobe        = 1'b0;
`ifdef USB_TX_UNDERRUN_EN
    abort_sent_d      = abort_sent_q;
`endif
    // Outputs stay quiet for the whole reset cycle, not only after it.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          // Types are captured here so later input changes cannot alter the packet.
          if (tx_trn_send_hsk) begin
            hsk_type_d  = tx_trn_hsk_type;
            data_type_d = tx_trn_data_type;
            state_d     = ST_HSK;
          end else if (tx_trn_data_start) begin
            hsk_type_d  = tx_trn_hsk_type;
            data_type_d = tx_trn_data_type;
            state_d     = ST_PID;
          end
        end
        ST_HSK: begin
          m_tvalid        = 1'b1;
          m_tlast         = 1'b1;
          m_tdata         = pid_byte(hsk_pid(hsk_type_q));
          tx_trn_hsk_sent = m_tready;
          if (m_tready) state_d = ST_IDLE;
        end
        ST_PID: begin
          m_tvalid  = 1'b1;
          m_tdata   = pid_byte(data_pid(data_type_q));
          crc_clear = 1'b1;
          if (m_tready) state_d = ST_DATA;
        end
        ST_DATA: begin
          m_tdata           = tx_trn_data;
          m_tvalid          = tx_trn_data_valid;
          tx_trn_data_ready = m_tready;
          crc_strobe        = tx_trn_data_valid && m_tready;
          if (crc_strobe && tx_trn_data_last) begin
            state_d = ST_CRC_LO;
          end else if (!tx_trn_data_valid && !tx_trn_data_start) begin
            // Source ended the packet early (or sent no payload at all).
            state_d = ST_CRC_LO;
          end
`ifdef USB_TX_UNDERRUN_EN
          else if (!tx_trn_data_valid) begin
            abort_sent_d = 1'b0;
            state_d      = ST_ABORT;
          end
`endif
        end
        ST_CRC_LO: begin
          m_tvalid = 1'b1;
          m_tdata  = ~crc[7:0];
          if (m_tready) state_d = ST_CRC_HI;
        end
        ST_CRC_HI: begin
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          m_tdata  = ~crc[15:8];
          if (m_tready) state_d = ST_IDLE;
        end
`ifdef USB_TX_UNDERRUN_EN
        ST_ABORT: begin
          if (!abort_sent_q) begin
            // Single marker byte telling the PHY to corrupt the packet.
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tuser  = 1'b1;
            if (m_tready) abort_sent_d = 1'b1;
          end else begin
            // Swallow the rest of the payload until the source lets go.
            tx_trn_data_ready = 1'b1;
            if ((tx_trn_data_valid && tx_trn_data_last) || !tx_trn_data_start) begin
              state_d = ST_IDLE;
            end
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tx_busy_o = !rst && (state_q != ST_IDLE);

endmodule
